// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet frame builder.
package eth_parser_pkg;

  localparam int unsigned MAC_W     = 48;
  localparam int unsigned ETYPE_W   = 16;
  localparam int unsigned VLAN_ID_W = 12;
  localparam int unsigned CNT_W     = 11;
  localparam int unsigned HDR_IDX_W = 5;

  localparam logic [15:0] ETH_TPID_VLAN       = 16'h8100;
  localparam int unsigned ETH_MIN_FRAME_BYTES = 60;

  typedef logic [MAC_W-1:0]   mac_addr_t;
  typedef logic [ETYPE_W-1:0] ethertype_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    PAD     = 2'd3
  } builder_state_t;

  typedef struct packed {
    mac_addr_t              dest_mac;
    mac_addr_t              src_mac;
    logic                   vlan_present;
    logic [VLAN_ID_W-1:0]   vlan_id;
    ethertype_t             ethertype;
  } eth_hdr_t;

  // Frame byte counter increment, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ethernet_frame_builder_if.sv
// Descriptor, payload-stream and frame-stream signals of the frame builder.
interface ethernet_frame_builder_if #(parameter int unsigned DATA_WIDTH = 8);
  import eth_parser_pkg::*;

  mac_addr_t             s_hdr_dest_mac;
  mac_addr_t             s_hdr_src_mac;
  logic                  s_hdr_vlan_present;
  logic [VLAN_ID_W-1:0]  s_hdr_vlan_id;
  ethertype_t            s_hdr_ethertype;
  logic                  s_hdr_valid;
  logic                  s_hdr_ready;

  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;

  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport slave (
    input  s_hdr_dest_mac, s_hdr_src_mac, s_hdr_vlan_present, s_hdr_vlan_id,
           s_hdr_ethertype, s_hdr_valid,
           s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_hdr_ready, s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_hdr_dest_mac, s_hdr_src_mac, s_hdr_vlan_present, s_hdr_vlan_id,
           s_hdr_ethertype, s_hdr_valid,
           s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_hdr_ready, s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/eth_header_serializer.sv
// Selects the header byte at a given index: MACs, optional 802.1Q tag, EtherType.
module eth_header_serializer
  import eth_parser_pkg::*;
(
  input  eth_hdr_t               hdr,
  input  logic [HDR_IDX_W-1:0]   idx,
  output logic [7:0]             hdr_byte,
  output logic                   hdr_last
);

  logic [2:0]           rel;
  logic [5:0]           sh;
  logic [HDR_IDX_W-1:0] et_base;

  always_comb begin
    hdr_byte = '0;
    hdr_last = 1'b0;
    rel      = 3'(idx - HDR_IDX_W'(6));
    sh       = '0;
    et_base  = hdr.vlan_present ? HDR_IDX_W'(16) : HDR_IDX_W'(12);
    if (idx < HDR_IDX_W'(6)) begin
      sh       = {3'd5 - idx[2:0], 3'b000};
      hdr_byte = 8'(hdr.dest_mac >> sh);
    end else if (idx < HDR_IDX_W'(12)) begin
      sh       = {3'd5 - rel, 3'b000};
      hdr_byte = 8'(hdr.src_mac >> sh);
    end else if (idx < et_base) begin
      // Tag occupies indices 12..15, so the low two bits pick the tag byte.
      case (idx[1:0])
        2'd0:    hdr_byte = ETH_TPID_VLAN[15:8];
        2'd1:    hdr_byte = ETH_TPID_VLAN[7:0];
        2'd2:    hdr_byte = {4'b0000, hdr.vlan_id[11:8]};
        default: hdr_byte = hdr.vlan_id[7:0];
      endcase
    end else if (idx == et_base) begin
      hdr_byte = hdr.ethertype[15:8];
    end else begin
      hdr_byte = hdr.ethertype[7:0];
      hdr_last = 1'b1;
    end
  end

endmodule

// File: rtl/ethernet_frame_builder.sv
// Builds Ethernet frames (header + payload, no FCS) into a registered AXI-stream stage.
// ETH_BUILDER_PAD_EN: pad frames with zero bytes up to the 60-byte minimum.
module ethernet_frame_builder
  import eth_parser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  ethernet_frame_builder_if.slave   bus,
  output logic                      busy
);

  builder_state_t        state_q, state_d;
  eth_hdr_t              hdr_q, hdr_d, hdr_in, hdr_sel;
  logic [HDR_IDX_W-1:0]  idx_q, idx_d, idx_sel;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_next;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [7:0]            hdr_byte;
  logic                  hdr_last;
  logic                  load, hdr_ready, hdr_accept, pay_ready, pay_accept;

  assign hdr_in = '{dest_mac:     bus.s_hdr_dest_mac,
                    src_mac:      bus.s_hdr_src_mac,
                    vlan_present: bus.s_hdr_vlan_present,
                    vlan_id:      bus.s_hdr_vlan_id,
                    ethertype:    bus.s_hdr_ethertype};

  // Output stage can take a beat when empty or draining this cycle.
  assign load       = !tvalid_q || bus.m_axis_tready;
  assign hdr_ready  = (state_q == IDLE) && !rst;
  assign hdr_accept = hdr_ready && bus.s_hdr_valid;
  assign pay_ready  = (state_q == PAYLOAD) && load && !rst;
  assign pay_accept = pay_ready && bus.s_axis_tvalid;

  // In IDLE the first header byte comes straight from the incoming descriptor.
  assign hdr_sel  = (state_q == IDLE) ? hdr_in : hdr_q;
  assign idx_sel  = (state_q == IDLE) ? '0 : idx_q;
  assign cnt_next = sat_inc((state_q == IDLE) ? '0 : cnt_q);

`ifdef ETH_BUILDER_PAD_EN
  logic min_met;
  assign min_met = cnt_next >= CNT_W'(ETH_MIN_FRAME_BYTES);
`endif

  eth_header_serializer u_hdr_ser (
    .hdr      (hdr_sel),
    .idx      (idx_sel),
    .hdr_byte (hdr_byte),
    .hdr_last (hdr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hdr_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hdr_accept) state_d = HEADER;
      HEADER:  if (load && hdr_last) state_d = PAYLOAD;
      PAYLOAD: if (pay_accept && bus.s_axis_tlast) begin
`ifdef ETH_BUILDER_PAD_EN
        state_d = min_met ? IDLE : PAD;
`else
        state_d = IDLE;
`endif
      end
`ifdef ETH_BUILDER_PAD_EN
      PAD:     if (load && min_met) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output-stage loading.
  always_comb begin
    hdr_d    = hdr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q && !bus.m_axis_tready;
    tlast_d  = tlast_q;
    case (state_q)
      IDLE: if (hdr_accept) begin
        hdr_d = hdr_in;
        idx_d = '0;
        cnt_d = '0;
        if (load) begin
          tdata_d  = DATA_WIDTH'(hdr_byte);
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          idx_d    = HDR_IDX_W'(1);
          cnt_d    = cnt_next;
        end
      end
      HEADER: if (load) begin
        tdata_d  = DATA_WIDTH'(hdr_byte);
        tvalid_d = 1'b1;
        tlast_d  = 1'b0;
        idx_d    = idx_q + HDR_IDX_W'(1);
        cnt_d    = cnt_next;
      end
      PAYLOAD: if (pay_accept) begin
        tdata_d  = bus.s_axis_tdata;
        tvalid_d = 1'b1;
`ifdef ETH_BUILDER_PAD_EN
        tlast_d  = bus.s_axis_tlast && min_met;
`else
        tlast_d  = bus.s_axis_tlast;
`endif
        cnt_d    = cnt_next;
      end
`ifdef ETH_BUILDER_PAD_EN
      PAD: if (load) begin
        tdata_d  = '0;
        tvalid_d = 1'b1;
        tlast_d  = min_met;
        cnt_d    = cnt_next;
      end
`endif
      default: ;
    endcase
  end

  assign bus.s_hdr_ready   = hdr_ready;
  assign bus.s_axis_tready = pay_ready;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign busy              = (state_q != IDLE);

endmodule
